// File: rtl/spi_master_multi_rtl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// spi_pkg : shared types and sizing helpers for the SPI master
// Rev 1.0
// ---------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam int SPI_MODE_W = 2;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int bits);
    return $clog2(2 * bits + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_master_multi_rtl_sclk_tick.sv
`default_nettype none
// ---------------------------------------------------------------
// spi_sclk_tick : CLK_DIV down-counter, pulses once per SCLK half-period
// Rev 1.0
// ---------------------------------------------------------------
module spi_sclk_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i || (cnt_q == '0)) begin
      cnt_q <= RELOAD;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  assign tick_o = (cnt_q == '0);

endmodule
`default_nettype wire

// File: rtl/spi_master_multi_rtl.sv
`default_nettype none
// ---------------------------------------------------------------
// spi_master_multi_rtl : multi-slave SPI master, all four modes per transfer
// Rev 1.0
// ---------------------------------------------------------------
module spi_master_multi_rtl
  import spi_pkg::*;
#(
  parameter  int BITS     = 21,
  parameter  int CLK_DIV  = 4,
  parameter  int N_SLAVES = 4,
  localparam int SEL_W    = sel_width(N_SLAVES)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [BITS-1:0]       i_data,
  input  logic                  i_send,
  input  logic [SEL_W-1:0]      i_slave,
  input  logic [SPI_MODE_W-1:0] i_mode,
  output logic [BITS-1:0]       o_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err,
  input  logic                  i_miso,
  output logic                  o_mosi,
  output logic                  o_sclk,
  output logic [N_SLAVES-1:0]   o_ss
);

  localparam int CNT_W = cnt_width(BITS);
  localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * BITS);

  state_t              state_q;
  spi_mode_t           mode_q;
  logic [BITS-1:0]     tx_q, rx_q, data_q;
  logic [CNT_W-1:0]    edge_q;
  logic                busy_q, done_q, err_q, mosi_q, sclk_q;
  logic [N_SLAVES-1:0] ss_q;

  logic tick, edge_evt, lead, slave_ok;

  spi_sclk_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk_i  (i_clk),
    .rst_i  (i_rst),
    .clr_i  (state_q == IDLE),
    .tick_o (tick)
  );

  // The SETUP tick produces the first SCLK edge; the tick after the last edge ends SHIFT.
  assign edge_evt = tick && ((state_q == SETUP) ||
                             ((state_q == SHIFT) && (edge_q != LAST_EDGE)));
  assign lead     = ~edge_q[0];
  assign slave_ok = (32'(i_slave) < N_SLAVES);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      mode_q  <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      data_q  <= '0;
      edge_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      mosi_q  <= 1'b0;
      sclk_q  <= 1'b0;
      ss_q    <= '1;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      if (edge_evt) begin
        sclk_q <= ~sclk_q;
        edge_q <= edge_q + CNT_W'(1);
        // Leading edges sample when CPHA=0, trailing edges sample when CPHA=1.
        if (lead ^ mode_q.cpha) begin
          rx_q <= {rx_q[BITS-2:0], i_miso};
        end else begin
          mosi_q <= tx_q[BITS-1];
          tx_q   <= tx_q << 1;
        end
      end
      case (state_q)
        IDLE: begin
          if (i_send) begin
            if (slave_ok) begin
              state_q <= SETUP;
              busy_q  <= 1'b1;
              mode_q  <= spi_mode_t'(i_mode);
              ss_q    <= ~(N_SLAVES'(1) << i_slave);
              sclk_q  <= i_mode[1];
              edge_q  <= '0;
              rx_q    <= '0;
              if (i_mode[0]) begin
                tx_q   <= i_data;
                mosi_q <= 1'b0;
              end else begin
                tx_q   <= i_data << 1;
                mosi_q <= i_data[BITS-1];
              end
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        SETUP: if (tick) state_q <= SHIFT;
        SHIFT: if (tick && (edge_q == LAST_EDGE)) state_q <= HOLD;
        HOLD: begin
          if (tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            ss_q    <= '1;
            sclk_q  <= mode_q.cpol;
            data_q  <= rx_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_data = data_q;
  assign o_busy = busy_q;
  assign o_done = done_q;
  assign o_err  = err_q;
  assign o_mosi = mosi_q;
  assign o_sclk = sclk_q;
  assign o_ss   = ss_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_multi_rtl.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_spi_master_multi_rtl : directed + random transfers against a bus-level slave model
// Rev 1.0
// ---------------------------------------------------------------
`timescale 1ns/1ps
module tb_spi_master_multi_rtl;

  localparam int BITS     = 21;
  localparam int CLK_DIV  = 4;
  localparam int N        = 4;
  localparam int DONE_CYC = (2 * BITS + 2) * CLK_DIV + 1;
  localparam logic [BITS-1:0] REPLY_BASE = 21'h15555;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            i_rst, i_send;
  logic            i_miso = 1'b0;
  logic [BITS-1:0] i_data;
  logic [1:0]      i_slave, i_mode;
  logic [BITS-1:0] o_data;
  logic            o_busy, o_done, o_err, o_mosi, o_sclk;
  logic [N-1:0]    o_ss;

  logic            e_send;
  logic [2:0]      e_slave;
  logic [BITS-1:0] e_data;
  logic            e_busy, e_done, e_err, e_mosi, e_sclk;
  logic [4:0]      e_ss;

  int tests = 0;
  int fails = 0;
  logic [BITS-1:0] exp_data;
  logic [1:0]      cur_mode;

  spi_master_multi_rtl #(.BITS(BITS), .CLK_DIV(CLK_DIV), .N_SLAVES(N)) u_dut (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_send(i_send), .i_slave(i_slave),
    .i_mode(i_mode), .o_data(o_data), .o_busy(o_busy), .o_done(o_done), .o_err(o_err),
    .i_miso(i_miso), .o_mosi(o_mosi), .o_sclk(o_sclk), .o_ss(o_ss)
  );

  // Five selects give a 3-bit index, so slave 5 is expressible and out of range.
  spi_master_multi_rtl #(.BITS(BITS), .CLK_DIV(CLK_DIV), .N_SLAVES(5)) u_dut5 (
    .i_clk(clk), .i_rst(i_rst), .i_data(i_data), .i_send(e_send), .i_slave(e_slave),
    .i_mode(2'b00), .o_data(e_data), .o_busy(e_busy), .o_done(e_done), .o_err(e_err),
    .i_miso(1'b1), .o_mosi(e_mosi), .o_sclk(e_sclk), .o_ss(e_ss)
  );

  // Slave k answers REPLY_BASE^k and records MOSI on its sampling edges.
  logic [BITS-1:0] s_tx, s_rx;
  logic            s_active = 1'b0;
  time             s_t0;

  always @(o_ss) begin : b_ss
    int k;
    if (!$isunknown(o_ss) && (o_ss != {N{1'b1}})) begin
      k = 0;
      for (int j = 0; j < N; j++) if (!o_ss[j]) k = j;
      s_tx     = REPLY_BASE ^ BITS'(k);
      s_rx     = '0;
      s_active = 1'b1;
      s_t0     = $time;
      if (!cur_mode[0]) begin
        i_miso = s_tx[BITS-1];
        s_tx   = s_tx << 1;
      end
    end else begin
      s_active = 1'b0;
    end
  end

  always @(o_sclk) begin
    if (s_active && ($time != s_t0)) begin
      if ((o_sclk !== cur_mode[1]) ^ cur_mode[0]) begin
        s_rx = {s_rx[BITS-2:0], o_mosi};
      end else begin
        i_miso = s_tx[BITS-1];
        s_tx   = s_tx << 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer; cont=1 means the caller already sits in the cycle that will be cycle 0.
  task automatic do_xfer(input logic [BITS-1:0] d, input logic [1:0] sl, input logic [1:0] m,
                         input bit cont, input bit hold, input int poke_cyc, input int rst_cyc,
                         input string tag);
    int cyc, bad, edges;
    logic last_sclk;
    logic [BITS-1:0] exp_rx;
    logic [N-1:0] exp_ss;
    exp_rx = REPLY_BASE ^ BITS'(sl);
    exp_ss = ~(N'(1) << sl);
    if (!cont) @(negedge clk);
    i_data = d; i_slave = sl; i_mode = m; cur_mode = m; i_send = 1'b1;
    @(negedge clk);
    if (!hold) i_send = 1'b0;
    cyc = 1; bad = 0; edges = 0; last_sclk = o_sclk;
    while ((o_done !== 1'b1) && (cyc <= DONE_CYC + 20)) begin
      if ((rst_cyc > 0) && (cyc == rst_cyc + 1)) begin
        chk({tag, "_rst_ss"}, o_ss, {N{1'b1}});
        chk({tag, "_rst_busy"}, o_busy, 1'b0);
        chk({tag, "_rst_data"}, o_data, '0);
        chk({tag, "_rst_done"}, o_done, 1'b0);
        i_rst = 1'b0;
        exp_data = '0;
        return;
      end
      if (o_sclk !== last_sclk) edges++;
      last_sclk = o_sclk;
      if ((o_ss !== exp_ss) || (o_busy !== 1'b1) || (o_data !== exp_data) || (o_err !== 1'b0)) bad++;
      if (((cyc <= CLK_DIV) || (cyc >= DONE_CYC - CLK_DIV)) && (o_sclk !== m[1])) bad++;
      if ((cyc <= CLK_DIV) && !m[0] && (o_mosi !== d[BITS-1])) bad++;
      if (cyc == poke_cyc) begin
        i_send = 1'b1; i_data = ~d; i_slave = sl + 2'd1; i_mode = ~m;
      end else if (cyc == poke_cyc + 1) begin
        i_send = 1'b0;
      end
      if (cyc == rst_cyc) i_rst = 1'b1;
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_done_cycle"}, 64'(cyc), 64'(DONE_CYC));
    chk({tag, "_rx_data"}, o_data, exp_rx);
    chk({tag, "_slave_saw_mosi"}, s_rx, d);
    chk({tag, "_sclk_edges"}, 64'(edges), 64'(2 * BITS));
    chk({tag, "_in_flight_bad"}, 64'(bad), 64'd0);
    chk({tag, "_ss_released"}, o_ss, {N{1'b1}});
    chk({tag, "_busy_cleared"}, o_busy, 1'b0);
    exp_data = exp_rx;
    if (!hold) begin
      @(negedge clk);
      chk({tag, "_done_one_cycle"}, o_done, 1'b0);
      chk({tag, "_idle_sclk_cpol"}, o_sclk, m[1]);
    end
  endtask

  initial begin : main
    int n;
    int no_done;
    logic mosi_before;
    i_rst = 1'b1; i_send = 1'b0; i_data = '0; i_slave = '0; i_mode = '0; cur_mode = '0;
    e_send = 1'b0; e_slave = '0; exp_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_data", o_data, '0);
    chk("reset_busy", o_busy, 1'b0);
    chk("reset_done_err", {o_done, o_err}, 2'b00);
    chk("reset_mosi_sclk", {o_mosi, o_sclk}, 2'b00);
    chk("reset_ss", o_ss, 4'hF);
    i_rst = 1'b0;

    do_xfer(21'h1ABCDE, 2'd0, 2'd0, 1'b0, 1'b0, 0, 0, "m0_s0");
    do_xfer(21'h00001, 2'd2, 2'd1, 1'b0, 1'b0, 0, 0, "m1_s2");
    do_xfer(21'h00001, 2'd2, 2'd2, 1'b0, 1'b0, 0, 0, "m2_s2");
    do_xfer(21'h00001, 2'd2, 2'd3, 1'b0, 1'b0, 0, 0, "m3_s2");

    do_xfer(BITS'($urandom), 2'd1, 2'd2, 1'b0, 1'b1, 0, 0, "b2b_first");
    do_xfer(BITS'($urandom), 2'd3, 2'd2, 1'b1, 1'b0, 0, 0, "b2b_second");
    n = 0;
    repeat (4) begin
      @(negedge clk);
      if ((o_busy !== 1'b0) || (o_done !== 1'b0)) n++;
    end
    chk("b2b_no_extra", 64'(n), 64'd0);

    do_xfer(21'h0F0F3, 2'd1, 2'd3, 1'b0, 1'b0, 50, 0, "poke_ignored");

    do_xfer(BITS'($urandom), 2'd3, 2'd1, 1'b0, 1'b0, 0, 60, "abort");
    no_done = 0;
    repeat (DONE_CYC) begin
      @(negedge clk);
      if ((o_done !== 1'b0) || (o_busy !== 1'b0)) no_done++;
    end
    chk("abort_no_done", 64'(no_done), 64'd0);
    do_xfer(BITS'($urandom), 2'd3, 2'd1, 1'b0, 1'b0, 0, 0, "after_abort");

    for (int r = 0; r < 4; r++) begin
      do_xfer(BITS'($urandom), 2'($urandom), 2'($urandom), 1'b0, 1'b0, 0, 0, "random");
    end

    @(negedge clk);
    e_slave = 3'd3; e_send = 1'b1;
    @(negedge clk);
    e_send = 1'b0;
    n = 1;
    while ((e_done !== 1'b1) && (n <= DONE_CYC + 20)) begin
      @(negedge clk);
      n++;
    end
    chk("e_valid_done_cycle", 64'(n), 64'(DONE_CYC));
    chk("e_valid_data", e_data, {BITS{1'b1}});
    @(negedge clk);
    mosi_before = e_mosi;
    e_slave = 3'd5; e_send = 1'b1;
    @(negedge clk);
    e_send = 1'b0;
    chk("err_pulse", e_err, 1'b1);
    chk("err_busy", e_busy, 1'b0);
    chk("err_ss", e_ss, 5'h1F);
    chk("err_data_kept", e_data, {BITS{1'b1}});
    @(negedge clk);
    chk("err_one_cycle", e_err, 1'b0);
    chk("err_still_idle", {e_busy, e_done, e_ss}, {2'b00, 5'h1F});
    chk("err_no_traffic", {e_mosi, e_sclk}, {mosi_before, 1'b0});
    chk("main_no_err", o_err, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
